// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer and MAC-side blocks: default widths,
// controller state encoding and small decode helpers.
package mac_sequencer_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 16;
  localparam int LEN_W_DEF      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  function automatic logic state_busy(input seq_state_t s);
    return (s != IDLE);
  endfunction

  function automatic logic state_streams(input seq_state_t s);
    return (s == STREAM);
  endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Command, operand, MAC and result signals between the sequencer (slave side)
// and its environment (master side: command source, operand source, MAC, result sink).
interface mac_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int LEN_W      = 8
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LEN_W-1:0]      cmd_len;

  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] op_c;

  logic [DATA_WIDTH-1:0] mac_b;
  logic [DATA_WIDTH-1:0] mac_c;
  logic                  mac_en;
  logic                  mac_clr;
  logic [ACC_WIDTH-1:0]  mac_result;

  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_WIDTH-1:0]  res_data;

  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_len,
    output cmd_ready,
    input  op_valid, op_b, op_c,
    output op_ready,
    output mac_b, mac_c, mac_en, mac_clr,
    input  mac_result,
    output res_valid, res_data,
    input  res_ready,
    output busy
  );

  modport master (
    output cmd_valid, cmd_len,
    input  cmd_ready,
    output op_valid, op_b, op_c,
    input  op_ready,
    input  mac_b, mac_c, mac_en, mac_clr,
    output mac_result,
    input  res_valid, res_data,
    output res_ready,
    input  busy
  );

endinterface

// File: rtl/mac_sequencer.sv
// Dot-product controller: accepts a length command, streams operand pairs into an
// external MAC, then captures the accumulator and holds it on a valid/ready result port.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mac_sequencer_if.slave bus
);

  seq_state_t            state_p0;
  seq_state_t            state_d;
  logic [LEN_W-1:0]      count_p0;
  logic [LEN_W-1:0]      count_d;
  logic [ACC_WIDTH-1:0]  res_data_p0;
  logic                  vld_p0;

  logic                  cmd_ready_c;
  logic                  op_ready_c;
  logic                  mac_en_c;
  logic                  mac_clr_c;
  logic [DATA_WIDTH-1:0] mac_b_c;
  logic [DATA_WIDTH-1:0] mac_c_c;
  logic                  capture_c;
  logic                  release_c;

  always_comb begin
    state_d     = state_p0;
    count_d     = count_p0;
    cmd_ready_c = 1'b0;
    op_ready_c  = 1'b0;
    mac_en_c    = 1'b0;
    mac_clr_c   = 1'b0;
    mac_b_c     = '0;
    mac_c_c     = '0;
    capture_c   = 1'b0;
    release_c   = 1'b0;

    unique case (state_p0)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          // Clearing on acceptance makes a zero-length command produce 0 without streaming.
          mac_clr_c = 1'b1;
          count_d   = bus.cmd_len;
          state_d   = (bus.cmd_len != '0) ? STREAM : DRAIN;
        end
      end

      STREAM: begin
        op_ready_c = 1'b1;
        mac_b_c    = bus.op_b;
        mac_c_c    = bus.op_c;
        mac_en_c   = bus.op_valid;
        if (bus.op_valid) begin
          count_d = count_p0 - LEN_W'(1);
          if (count_p0 == LEN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // The MAC register already holds the last product, so capture now.
        capture_c = 1'b1;
        state_d   = HOLD;
      end

      HOLD: begin
        if (bus.res_ready) begin
          release_c = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- stage p0: controller state and pair counter ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0 <= IDLE;
      count_p0 <= '0;
    end else begin
      state_p0 <= state_d;
      count_p0 <= count_d;
    end
  end

  // ---- stage p0: captured result and its valid ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_data_p0 <= '0;
      vld_p0      <= 1'b0;
    end else begin
      if (capture_c) begin
        res_data_p0 <= bus.mac_result;
      end
      if (capture_c) begin
        vld_p0 <= 1'b1;
      end else if (release_c) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.op_ready  = op_ready_c && state_streams(state_p0);
  assign bus.mac_b     = mac_b_c;
  assign bus.mac_c     = mac_c_c;
  assign bus.mac_en    = mac_en_c;
  assign bus.mac_clr   = mac_clr_c;
  assign bus.res_valid = vld_p0;
  assign bus.res_data  = res_data_p0;
  assign bus.busy      = state_busy(state_p0);

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: a behavioural MAC behind the mac_* ports and
// a sum-of-products reference with latency/handshake checks per scenario.
module tb_mac_sequencer;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_sequencer_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_W(LW)) bus ();

  mac_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural MAC: clear has priority, accumulates modulo 2^AW.
  logic [AW-1:0] acc = '0;
  logic [AW-1:0] ext_b, ext_c;
  assign ext_b = {{(AW-DW){1'b0}}, bus.mac_b};
  assign ext_c = {{(AW-DW){1'b0}}, bus.mac_c};
  always @(posedge clk) begin
    if (bus.mac_clr === 1'b1)     acc <= '0;
    else if (bus.mac_en === 1'b1) acc <= acc + ext_b * ext_c;
  end
  assign bus.mac_result = acc;

  int en_total = 0;
  always @(posedge clk) if (bus.mac_en === 1'b1) en_total++;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] pb_q[$];
  logic [DW-1:0] pc_q[$];

  task automatic run_dot(input int len, input int gap, input int hold, input string tag);
    int            exp_sum;
    int            en0;
    int            n;
    logic [AW-1:0] exp_res;
    logic [AW-1:0] held;
    logic [DW-1:0] b, c;
    exp_sum = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.mac_clr !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept cmd_ready=%b mac_clr=%b required 1/1", tag, bus.cmd_ready, bus.mac_clr);
    end
    en0 = en_total;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (bus.mac_en !== 1'b0 || bus.op_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s_stall mac_en=%b op_ready=%b required 0/1", tag, bus.mac_en, bus.op_ready);
        end
        @(posedge clk); #1;
      end
      b = pb_q.pop_front();
      c = pc_q.pop_front();
      exp_sum += int'(b) * int'(c);
      bus.op_valid = 1'b1;
      bus.op_b     = b;
      bus.op_c     = c;
      @(negedge clk);
      checks++;
      if (bus.mac_en !== 1'b1 || bus.op_ready !== 1'b1 || bus.mac_b !== b || bus.mac_c !== c) begin
        failures++;
        $display("FAIL %s_pair%0d mac_en=%b op_ready=%b mac_b=%0d mac_c=%0d required 1/1/%0d/%0d",
                 tag, i, bus.mac_en, bus.op_ready, bus.mac_b, bus.mac_c, b, c);
      end
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
    end
    bus.op_b = $urandom;
    bus.op_c = $urandom;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1 || bus.mac_en !== 1'b0 ||
        bus.mac_b !== '0 || bus.mac_c !== '0 || bus.op_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain res_valid=%b busy=%b mac_en=%b mac_b=%0d mac_c=%0d op_ready=%b required 0/1/0/0/0/0",
               tag, bus.res_valid, bus.busy, bus.mac_en, bus.mac_b, bus.mac_c, bus.op_ready);
    end
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL %s_latency edges_after_last_accept=%0d required 1", tag, n);
    end
    checks++;
    if (en_total - en0 != len) begin
      failures++;
      $display("FAIL %s_en_count mac_en_cycles=%0d required %0d", tag, en_total - en0, len);
    end
    exp_res = exp_sum[AW-1:0];
    checks++;
    if (bus.res_data !== exp_res) begin
      failures++;
      $display("FAIL %s_result res_data=%h required %h", tag, bus.res_data, exp_res);
    end
    held = exp_res;
    for (int h = 0; h < hold; h++) begin
      bus.cmd_valid = 1'b1;
      bus.op_valid  = 1'b1;
      #1;
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== held || bus.cmd_ready !== 1'b0 ||
          bus.op_ready !== 1'b0 || bus.mac_clr !== 1'b0 || bus.mac_en !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold%0d res_valid=%b res_data=%h cmd_ready=%b op_ready=%b mac_clr=%b mac_en=%b required 1/%h/0/0/0/0",
                 tag, h, bus.res_valid, bus.res_data, bus.cmd_ready, bus.op_ready, bus.mac_clr, bus.mac_en, held);
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    checks++;
    if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_release res_valid=%b cmd_ready=%b busy=%b required 0/1/0",
               tag, bus.res_valid, bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic load_pairs(input int b0, input int c0, input int b1, input int c1,
                            input int b2, input int c2, input int n);
    pb_q.delete();
    pc_q.delete();
    if (n > 0) begin pb_q.push_back(DW'(b0)); pc_q.push_back(DW'(c0)); end
    if (n > 1) begin pb_q.push_back(DW'(b1)); pc_q.push_back(DW'(c1)); end
    if (n > 2) begin pb_q.push_back(DW'(b2)); pc_q.push_back(DW'(c2)); end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.op_valid  = 1'b0;
    bus.op_b      = '0;
    bus.op_c      = '0;
    bus.res_ready = 1'b0;
    #12;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== '0 ||
        bus.op_ready !== 1'b0 || bus.mac_en !== 1'b0 || bus.mac_clr !== 1'b0) begin
      failures++;
      $display("FAIL reset cmd_ready=%b busy=%b res_valid=%b res_data=%h op_ready=%b mac_en=%b mac_clr=%b required 1/0/0/0/0/0/0",
               bus.cmd_ready, bus.busy, bus.res_valid, bus.res_data, bus.op_ready, bus.mac_en, bus.mac_clr);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    load_pairs(2, 3, 4, 5, 1, 7, 3);
    run_dot(3, 0, 0, "basic");
  endtask

  task automatic test_zero_len();
    load_pairs(0, 0, 0, 0, 0, 0, 0);
    run_dot(0, 0, 0, "zero_len");
  endtask

  task automatic test_gaps();
    load_pairs(3, 3, 2, 2, 0, 0, 2);
    run_dot(2, 3, 0, "gaps");
  endtask

  task automatic test_backpressure();
    load_pairs(9, 11, 6, 4, 0, 0, 2);
    run_dot(2, 0, 5, "backpressure");
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(4);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_b      = DW'(7);
    bus.op_c      = DW'(9);
    @(posedge clk); #1;
    bus.op_valid  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.op_ready !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid busy=%b res_valid=%b op_ready=%b cmd_ready=%b required 0/0/0/1",
               bus.busy, bus.res_valid, bus.op_ready, bus.cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    load_pairs(5, 6, 0, 0, 0, 0, 1);
    run_dot(1, 0, 0, "after_reset");
  endtask

  task automatic test_wrap();
    load_pairs(255, 255, 255, 255, 0, 0, 2);
    run_dot(2, 0, 0, "wrap");
  endtask

  task automatic test_random();
    int len;
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(0, 7);
      pb_q.delete();
      pc_q.delete();
      for (int i = 0; i < len; i++) begin
        pb_q.push_back(DW'($urandom_range(0, 255)));
        pc_q.push_back(DW'($urandom_range(0, 255)));
      end
      run_dot(len, $urandom_range(0, 2), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_back_to_back();
    load_pairs(10, 10, 20, 3, 0, 0, 2);
    run_dot(2, 0, 0, "b2b_first");
    load_pairs(1, 200, 0, 0, 0, 0, 1);
    run_dot(1, 0, 0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
